// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front end.
// Issues in-order fetch requests from the PC, buffers up to two returned
// instructions for the decode stage, and restarts cleanly on a redirect by
// dropping the responses that were still in flight.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  input  logic        ID_Wr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC,
  output logic        IF_AdEL,
  output logic        IF_Valid
);

  logic [31:0] pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        buf_adel  [2];
  logic [1:0]  occ;
  logic [1:0]  outstanding;
  logic [1:0]  discard;
  logic        halt;
  logic [31:0] req_pc    [2];

  logic [31:0] n_buf_pc    [2];
  logic [31:0] n_buf_instr [2];
  logic        n_buf_adel  [2];
  logic [1:0]  n_occ;
  logic [31:0] n_req_pc    [2];

  logic        credit_ok;
  logic        accept;
  logic        resp;
  logic        keep;
  logic        pop;
  logic        err_push;
  logic [1:0]  base;
  logic        req_idx;

  // Outstanding requests plus buffered entries never exceed the buffer depth,
  // so every response that is kept always finds a free slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, occ}) < 3'd2;
  assign inst_req  = rst & (pc[1:0] == 2'b00) & ~halt & ~Redirect_Valid & credit_ok;
  assign inst_addr = pc;
  assign accept    = inst_req & inst_addr_ok;
  assign resp      = inst_data_ok & (outstanding != 2'd0);
  assign keep      = resp & (discard == 2'd0) & ~Redirect_Valid;
  assign pop       = (occ != 2'd0) & ID_Wr;
  assign err_push  = (pc[1:0] != 2'b00) & ~halt & (outstanding == 2'd0) &
                     (occ != 2'd2) & ~Redirect_Valid;
  assign base      = occ - {1'b0, pop};
  assign req_idx   = (outstanding == 2'd1) & ~resp;

  assign IF_Valid  = (occ != 2'd0);
  assign IF_PC     = IF_Valid ? buf_pc[0]    : 32'h0;
  assign IF_Instr  = IF_Valid ? buf_instr[0] : 32'h0;
  assign IF_AdEL   = IF_Valid ? buf_adel[0]  : 1'b0;

  // Next buffer contents: pop shifts the tail forward, then a kept response or
  // an address-error entry lands behind whatever remains; redirect empties it.
  always_comb begin
    n_buf_pc    = buf_pc;
    n_buf_instr = buf_instr;
    n_buf_adel  = buf_adel;
    n_occ       = occ;
    if (Redirect_Valid) begin
      n_occ = 2'd0;
    end else begin
      if (pop) begin
        n_buf_pc[0]    = buf_pc[1];
        n_buf_instr[0] = buf_instr[1];
        n_buf_adel[0]  = buf_adel[1];
      end
      if (keep) begin
        n_buf_pc[base[0]]    = req_pc[0];
        n_buf_instr[base[0]] = inst_rdata;
        n_buf_adel[base[0]]  = 1'b0;
      end else if (err_push) begin
        n_buf_pc[base[0]]    = pc;
        n_buf_instr[base[0]] = 32'h0;
        n_buf_adel[base[0]]  = 1'b1;
      end
      n_occ = base + {1'b0, keep | err_push};
    end
  end

  // Remember the PC of every accepted request so each response is tagged with
  // the address it was fetched from, oldest first.
  always_comb begin
    n_req_pc = req_pc;
    if (resp) begin
      n_req_pc[0] = req_pc[1];
    end
    if (accept) begin
      n_req_pc[req_idx] = pc;
    end
  end

  // All architectural state; in-flight responses are abandoned on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      occ         <= 2'd0;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      halt        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= 32'h0;
        buf_instr[i] <= 32'h0;
        buf_adel[i]  <= 1'b0;
        req_pc[i]    <= 32'h0;
      end
    end else begin
      buf_pc      <= n_buf_pc;
      buf_instr   <= n_buf_instr;
      buf_adel    <= n_buf_adel;
      occ         <= n_occ;
      req_pc      <= n_req_pc;
      outstanding <= outstanding - {1'b0, resp} + {1'b0, accept};
      if (Redirect_Valid) begin
        pc      <= Redirect_PC;
        halt    <= 1'b0;
        discard <= outstanding - {1'b0, resp};
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if (err_push) begin
          halt <= 1'b1;
        end
        if (resp && (discard != 2'd0)) begin
          discard <= discard - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: drives if_fetch_unit with directed scenarios and random
// traffic, comparing every cycle against a queue-based behavioural model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        Redirect_Valid;
  logic [31:0] Redirect_PC;
  logic        ID_Wr;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC;
  logic        IF_AdEL;
  logic        IF_Valid;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .Redirect_Valid(Redirect_Valid),
    .Redirect_PC   (Redirect_PC),
    .ID_Wr         (ID_Wr),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .IF_Instr      (IF_Instr),
    .IF_PC         (IF_PC),
    .IF_AdEL       (IF_AdEL),
    .IF_Valid      (IF_Valid)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          drop;
  } out_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          adel;
  } ent_t;

  out_t        q_out[$];
  ent_t        q_buf[$];
  logic [31:0] m_pc;
  bit          m_halt;

  int          checks;
  int          errors;

  bit          s_req;
  bit          s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  bit          s_adel;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_A5A5) + 32'h0001_3579;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q_out.delete();
    q_buf.delete();
    m_pc   = RESET_PC;
    m_halt = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then let the
  // model follow the architectural rules across the rising edge.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc,
                               input bit aok, input bit dok, input bit idwr);
    bit   d;
    bit   m_req;
    bit   accept;
    int   out_start;
    int   buf_start;
    out_t r;
    ent_t e;
    out_t o;
    @(negedge clk);
    d              = dok && (q_out.size() > 0);
    Redirect_Valid = redir;
    Redirect_PC    = rpc;
    inst_addr_ok   = aok;
    inst_data_ok   = d;
    inst_rdata     = d ? instr_of(q_out[0].pc) : $urandom();
    ID_Wr          = idwr;
    #1;
    m_req = (m_pc[1:0] == 2'b00) && !m_halt && !redir && ((q_out.size() + q_buf.size()) < 2);
    checkOutput("inst_req", 32'(inst_req), 32'(m_req));
    checkOutput("inst_addr", inst_addr, m_pc);
    checkOutput("if_valid", 32'(IF_Valid), 32'(q_buf.size() > 0));
    checkOutput("if_pc", IF_PC, (q_buf.size() > 0) ? q_buf[0].pc : 32'h0);
    checkOutput("if_instr", IF_Instr, (q_buf.size() > 0) ? q_buf[0].instr : 32'h0);
    checkOutput("if_adel", 32'(IF_AdEL), (q_buf.size() > 0) ? 32'(q_buf[0].adel) : 32'h0);
    s_req   = inst_req;
    s_valid = IF_Valid;
    s_pc    = IF_PC;
    s_instr = IF_Instr;
    s_adel  = IF_AdEL;
    @(posedge clk);
    accept    = m_req && aok;
    out_start = q_out.size();
    buf_start = q_buf.size();
    r.pc   = 32'h0;
    r.drop = 1'b1;
    if (d) r = q_out.pop_front();
    if (redir) begin
      q_buf.delete();
      foreach (q_out[i]) q_out[i].drop = 1'b1;
      m_pc   = rpc;
      m_halt = 1'b0;
    end else begin
      if (buf_start > 0 && idwr) void'(q_buf.pop_front());
      if (d && !r.drop) begin
        e.pc = r.pc; e.instr = instr_of(r.pc); e.adel = 1'b0;
        q_buf.push_back(e);
      end
      if (m_pc[1:0] != 2'b00 && !m_halt && out_start == 0 && buf_start < 2) begin
        e.pc = m_pc; e.instr = 32'h0; e.adel = 1'b1;
        q_buf.push_back(e);
        m_halt = 1'b1;
      end
      if (accept) begin
        o.pc = m_pc; o.drop = 1'b0;
        q_out.push_back(o);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Asserts reset part-way through a cycle and checks it takes effect at once.
  task automatic resetDut();
    @(negedge clk);
    #2;
    rst            = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_PC    = 32'h0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'h0;
    ID_Wr          = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(IF_Valid), 32'h0);
    checkOutput("rst_req", 32'(inst_req), 32'h0);
    checkOutput("rst_if_pc", IF_PC, 32'h0);
    checkOutput("rst_if_instr", IF_Instr, 32'h0);
    checkOutput("rst_if_adel", 32'(IF_AdEL), 32'h0);
    checkOutput("rst_addr", inst_addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    bit          found;
    bit          saw_req;
    logic [31:0] first_pc;
    logic [31:0] rpc;
    logic [31:0] rnd;
    int          kind;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_PC = 32'h0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    ID_Wr = 1'b0;
    modelReset();
    resetDut();

    $display("[TB] streaming");
    found = 1'b0;
    first_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (s_valid && !found) begin found = 1'b1; first_pc = s_pc; end
    end
    checkOutput("stream_found", 32'(found), 32'h1);
    checkOutput("stream_first_pc", first_pc, RESET_PC);

    $display("[TB] stall");
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("stall_valid", 32'(s_valid), 32'h1);
    checkOutput("stall_req", 32'(s_req), 32'h0);
    checkOutput("stall_head", s_pc, RESET_PC);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] redirect with two outstanding");
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8000_0100, 1'b1, 1'b0, 1'b1);
    found = 1'b0;
    first_pc = 32'h0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (s_valid) begin found = 1'b1; first_pc = s_pc; end
    end
    checkOutput("redir_found", 32'(found), 32'h1);
    checkOutput("redir_first_pc", first_pc, 32'h8000_0100);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 32'h8000_0102, 1'b1, 1'b1, 1'b0);
    found = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (s_req) saw_req = 1'b1;
      if (s_valid) found = 1'b1;
    end
    checkOutput("mis_found", 32'(found), 32'h1);
    checkOutput("mis_no_req", 32'(saw_req), 32'h0);
    checkOutput("mis_pc", s_pc, 32'h8000_0102);
    checkOutput("mis_adel", 32'(s_adel), 32'h1);
    checkOutput("mis_instr", s_instr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("mis_idle_valid", 32'(s_valid), 32'h0);
    checkOutput("mis_idle_req", 32'(s_req), 32'h0);
    applyStimulus(1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] simultaneous redirect, response and pop");
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sim_empty", 32'(s_valid), 32'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    $display("[TB] reset with full buffer");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("prerst_valid", 32'(s_valid), 32'h1);
    resetDut();
    found = 1'b0;
    first_pc = 32'h0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (s_valid) begin found = 1'b1; first_pc = s_pc; end
    end
    checkOutput("postrst_found", 32'(found), 32'h1);
    checkOutput("postrst_first_pc", first_pc, RESET_PC);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      rnd  = $urandom();
      kind = $urandom_range(0, 9);
      if (kind == 0)      rpc = {rnd[31:2], 2'b00} | 32'h1 | {30'h0, rnd[1], 1'b0};
      else if (kind == 1) rpc = 32'hFFFF_FFF8;
      else                rpc = {rnd[31:2], 2'b00};
      applyStimulus($urandom_range(0, 99) < 4, rpc,
                    $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 65);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
